// File: rtl/execute_reg.sv
// Y86-64 decode-to-execute pipeline register with valA/valB forwarding,
// load/use hazard detection and a saturating bubble counter.
module execute_reg #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [3:0]  RESET_PC_NOP = 4'h1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_stat_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       D_ifun_i,
  input  logic [63:0]      D_valC_i,
  input  logic [63:0]      D_valP_i,
  input  logic [63:0]      d_rvalA_i,
  input  logic [63:0]      d_rvalB_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       d_dstE_i,
  input  logic [3:0]       d_dstM_i,
  input  logic [3:0]       e_dstE_i,
  input  logic [63:0]      e_valE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [63:0]      m_valM_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [63:0]      M_valE_i,
  input  logic [3:0]       W_dstM_i,
  input  logic [63:0]      W_valM_i,
  input  logic [3:0]       W_dstE_i,
  input  logic [63:0]      W_valE_i,
  input  logic             E_bubble_i,
  output logic [3:0]       E_stat_o,
  output logic [3:0]       E_icode_o,
  output logic [3:0]       E_ifun_o,
  output logic [63:0]      E_valC_o,
  output logic [63:0]      E_valA_o,
  output logic [63:0]      E_valB_o,
  output logic [3:0]       E_dstE_o,
  output logic [3:0]       E_dstM_o,
  output logic [3:0]       E_srcA_o,
  output logic [3:0]       E_srcB_o,
  output logic             load_use_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [3:0] SAOK    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  logic [63:0] fwd_a, fwd_b;
  logic        bubble;

  // RNONE sources are excluded so an idle bypass stage (dst = RNONE) never hits.
  always_comb begin
    fwd_a = d_rvalA_i;
    if (D_icode_i == ICALL || D_icode_i == IJXX)       fwd_a = D_valP_i;
    else if (d_srcA_i != RNONE && d_srcA_i == e_dstE_i) fwd_a = e_valE_i;
    else if (d_srcA_i != RNONE && d_srcA_i == M_dstM_i) fwd_a = m_valM_i;
    else if (d_srcA_i != RNONE && d_srcA_i == M_dstE_i) fwd_a = M_valE_i;
    else if (d_srcA_i != RNONE && d_srcA_i == W_dstM_i) fwd_a = W_valM_i;
    else if (d_srcA_i != RNONE && d_srcA_i == W_dstE_i) fwd_a = W_valE_i;
  end

  always_comb begin
    fwd_b = d_rvalB_i;
    if (d_srcB_i != RNONE && d_srcB_i == e_dstE_i)      fwd_b = e_valE_i;
    else if (d_srcB_i != RNONE && d_srcB_i == M_dstM_i) fwd_b = m_valM_i;
    else if (d_srcB_i != RNONE && d_srcB_i == M_dstE_i) fwd_b = M_valE_i;
    else if (d_srcB_i != RNONE && d_srcB_i == W_dstM_i) fwd_b = W_valM_i;
    else if (d_srcB_i != RNONE && d_srcB_i == W_dstE_i) fwd_b = W_valE_i;
  end

  assign load_use_o = (E_icode_o == IMRMOVQ || E_icode_o == IPOPQ) && (E_dstM_o != RNONE) &&
                      (E_dstM_o == d_srcA_i || E_dstM_o == d_srcB_i);

  assign bubble = E_bubble_i | load_use_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      E_stat_o  <= SAOK;
      E_icode_o <= RESET_PC_NOP;
      E_ifun_o  <= 4'h0;
      E_valC_o  <= 64'h0;
      E_valA_o  <= 64'h0;
      E_valB_o  <= 64'h0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else if (bubble) begin
      E_stat_o  <= SAOK;
      E_icode_o <= RESET_PC_NOP;
      E_ifun_o  <= 4'h0;
      E_valC_o  <= 64'h0;
      E_valA_o  <= 64'h0;
      E_valB_o  <= 64'h0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else begin
      E_stat_o  <= D_stat_i;
      E_icode_o <= D_icode_i;
      E_ifun_o  <= D_ifun_i;
      E_valC_o  <= D_valC_i;
      E_valA_o  <= fwd_a;
      E_valB_o  <= fwd_b;
      E_dstE_o  <= d_dstE_i;
      E_dstM_o  <= d_dstM_i;
      E_srcA_o  <= d_srcA_i;
      E_srcB_o  <= d_srcB_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble && bubble_cnt_o != '1) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/execute_reg.md
Name: execute_reg

Overview:
- Decode-to-execute pipeline register of the Y86-64 five-stage pipeline; captures decode-stage results and presents them to the execute stage as E_* signals.
- Resolves operand forwarding for valA/valB at capture time, choosing among e/M/W bypass sources, register-file values, and valP.
- Detects load/use hazards against the instruction currently in E and inserts bubbles on external request.
- Keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
- CNT_W, 32, width of bubble counter.
- RESET_PC_NOP, 1, icode driven on bubble/reset (value of `INOP).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- D_stat_i  in  4  status of instruction in D.
- D_icode_i  in  4  icode in D.
- D_ifun_i  in  4  ifun in D.
- D_valC_i  in  64  constant word.
- D_valP_i  in  64  incremented PC.
- d_rvalA_i  in  64  register-file read for srcA.
- d_rvalB_i  in  64  register-file read for srcB.
- d_srcA_i, d_srcB_i, d_dstE_i, d_dstM_i  in  4 each  decoded register IDs (`RNONE = 4'hF).
- e_dstE_i  in  4, e_valE_i  in  64  execute-stage bypass.
- M_dstM_i  in  4, m_valM_i  in  64  memory-stage load bypass.
- M_dstE_i  in  4, M_valE_i  in  64  memory-stage ALU bypass.
- W_dstM_i  in  4, W_valM_i  in  64  write-back load bypass.
- W_dstE_i  in  4, W_valE_i  in  64  write-back ALU bypass.
- E_bubble_i  in  1  external bubble request (branch mispredict).
- E_stat_o, E_icode_o, E_ifun_o  out  4 each.
- E_valC_o, E_valA_o, E_valB_o  out  64 each.
- E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  4 each.
- load_use_o  out  1  combinational hazard flag to F/D stall logic.
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (asynchronous, rst_i=1) and every bubble load the same register image:
  - E_stat=SAOK (4'h1), E_icode=`INOP (4'h1), E_ifun=0.
  - E_valC/E_valA/E_valB=0.
  - E_dstE/E_dstM/E_srcA/E_srcB=`RNONE.
- bubble_cnt_o resets to 0.
- Forwarding for valA is combinational, first match wins:
  1. D_icode in {`ICALL, `IJXX} -> D_valP_i.
  2. d_srcA==e_dstE -> e_valE.
  3. d_srcA==M_dstM -> m_valM.
  4. d_srcA==M_dstE -> M_valE.
  5. d_srcA==W_dstM -> W_valM.
  6. d_srcA==W_dstE -> W_valE.
  7. Otherwise d_rvalA_i.
- Forwarding for valB uses the same order against d_srcB, without the valP rule.
- A source equal to `RNONE never matches any bypass; its value is d_rval (0 from decode).
- load_use_o = (E_icode_o ∈ {`IMRMOVQ, `IPOPQ}) && E_dstM_o != `RNONE && (E_dstM_o==d_srcA_i || E_dstM_o==d_srcB_i).
  - load_use_o is purely combinational from registered E state and decode inputs.
- Per rising edge:
  - bubble = E_bubble_i | load_use_o.
  - If bubble: load the bubble image.
  - Else: capture D_stat/icode/ifun/valC, the forwarded valA/valB, d_dstE/dstM/srcA/srcB.
- Latency: one cycle; decode values appear on E_* the edge after they are presented.
- No stall input: the E register always advances, either with a bubble or with new data.
- Simultaneous E_bubble_i and load_use_o: a single bubble is inserted and the counter increments by 1.
- Counter increments on each edge with bubble=1 and holds at all-ones (no wrap).
- Reset asserted mid-operation clears all state immediately, regardless of the clock.
- The first edge after deassertion behaves normally.
- After a bubble is loaded, E_icode=`INOP, so load_use_o deasserts next cycle. A load/use therefore produces exactly one bubble.

Test Plan:
1. Reset: assert rst_i with no clock edge -> E_icode=1, E_dstE=F, E_valA=0, bubble_cnt=0 immediately.
2. Forward priority: d_srcA=3, e_dstE=3 (valE=0x11), M_dstE=3 (0x22), W_dstE=3 (0x33), D_icode=`IOPQ -> E_valA=0x11 next edge. Remove the e match -> 0x22. Remove M -> 0x33. Remove all -> d_rvalA.
3. Call valP: D_icode=`ICALL, D_valP=0x1000, d_srcA=F while e_dstE=F -> E_valA=0x1000. `RNONE source with e_dstE=F -> no forward, E_valB=d_rvalB.
4. Load/use: E holds mrmovq with E_dstM=2; decode presents d_srcB=2 -> load_use_o=1. Next edge E_icode=1, counter=1, load_use_o=0. Following edge captures the decode instruction with valB forwarded from m_valM.
5. Simultaneous: E_bubble_i=1 together with load_use -> one bubble, counter +1 only.
6. Saturation: with CNT_W=4, 20 consecutive bubbles -> counter stops at 15. Mid-run reset -> 0.
